sample_stream: RTL

SAMPLE_STREAM -- requirements
Module: sample_stream

---
 rtl/sample_stream.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/sample_stream.sv
// Sample buffer and byte serialiser: strobed samples are queued in a circular FIFO
// and emitted most-significant byte first over a valid/accept byte interface.
module sample_stream #(
  parameter int SAMPLE_BYTES = 6,
  parameter int FIFO_DEPTH   = 16,
  parameter int LOST_BIT     = 41,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sample_rdy,
  input  logic [SAMPLE_BYTES*8-1:0]     sample,
  output logic                          data_avail,
  output logic [7:0]                    data,
  input  logic                          data_accepted,
  input  logic                          request_length,
  output logic [COUNT_WIDTH-1:0]        length,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int SW = SAMPLE_BYTES * 8;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int IW = (SAMPLE_BYTES > 1) ? $clog2(SAMPLE_BYTES) : 1;
  localparam logic [PW:0]          LVL_ONE  = (PW+1)'(1);
  localparam logic [PW:0]          LVL_FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0]        PTR_ONE  = PW'(1);
  localparam logic [IW-1:0]        IDX_ONE  = IW'(1);
  localparam logic [IW-1:0]        IDX_LAST = IW'(SAMPLE_BYTES - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [SW-1:0]          mem_q [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]            level_q, level_d;
  logic                   lost_q, lost_d, ovf_q, ovf_d;
  logic [SW-1:0]          shift_q, shift_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d, length_q, length_d;

  logic          full_s, wr_en_s, drop_s, pop_s, accept_s, last_s;
  logic [SW-1:0] wr_word_s;

  always_comb begin
    full_s    = (level_q == LVL_FULL);
    wr_en_s   = sample_rdy && !full_s;
    drop_s    = sample_rdy && full_s;
    pop_s     = (state_q == IDLE) && (level_q != '0);
    accept_s  = (state_q == SEND) && data_accepted;
    last_s    = (idx_q == IDX_LAST);
    // A pending loss is folded into the flag bit of the next stored sample.
    wr_word_s = sample;
    wr_word_s[LOST_BIT] = sample[LOST_BIT] | lost_q;
  end

  always_comb begin
    wr_ptr_d = wr_en_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({wr_en_s, pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    if (wr_en_s) begin
      lost_d = 1'b0;
    end else if (drop_s) begin
      lost_d = 1'b1;
    end else begin
      lost_d = lost_q;
    end
    ovf_d = ovf_q | drop_s;
  end

  always_comb begin
    case (state_q)
      IDLE:    state_d = pop_s ? SEND : IDLE;
      SEND:    state_d = (accept_s && last_s) ? IDLE : SEND;
      default: state_d = IDLE;
    endcase
  end

  // Shifting left per accepted byte keeps the current byte in the top lane.
  always_comb begin
    if (pop_s) begin
      shift_d = mem_q[rd_ptr_q];
      idx_d   = '0;
    end else if (accept_s) begin
      shift_d = shift_q << 8;
      idx_d   = last_s ? '0 : (idx_q + IDX_ONE);
    end else begin
      shift_d = shift_q;
      idx_d   = idx_q;
    end
  end

  always_comb begin
    if (request_length) begin
      length_d = count_q;
      count_d  = wr_en_s ? CNT_ONE : '0;
    end else if (wr_en_s && (count_q != CNT_MAX)) begin
      length_d = length_q;
      count_d  = count_q + CNT_ONE;
    end else begin
      length_d = length_q;
      count_d  = count_q;
    end
  end

  always_comb begin
    data_avail = (state_q == SEND);
    data       = shift_q[SW-1 -: 8];
    length     = length_q;
    fifo_level = level_q;
    overflow   = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      lost_q   <= 1'b0;
      ovf_q    <= 1'b0;
      shift_q  <= '0;
      idx_q    <= '0;
      count_q  <= '0;
      length_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      lost_q   <= lost_d;
      ovf_q    <= ovf_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      count_q  <= count_d;
      length_q <= length_d;
    end
  end

  // Storage needs no reset: occupancy is tracked entirely by the pointers and level.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en_s) begin
      mem_q[wr_ptr_q] <= wr_word_s;
    end
  end

endmodule
